hwpe_ctrl_evt_irq: RTL and testbench
====================================

Name: hwpe_ctrl_evt_irq

Overview:
- Downstream consumer of the control slave's per-core event outputs (flags evt[core][evt], one-cycle pulses; bit 0 = job done).
- Counts pending events per core and event line, and turns them into per-core interrupt requests.
- Two interrupt modes: level (held until software acknowledges) or pulse (one spaced pulse per pending event).
- Sits between the HWPE control slave and the cluster event unit.

Parameters:
- N_CORES, 4, number of cores / interrupt targets.
- N_EVT, 2, event lines per core (line 0 = done).
- CNT_WIDTH, 4, width of each pending counter; saturates at 2**CNT_WIDTH-1.
- PULSE_MODE, 0, 0 = level irq, 1 = pulse irq.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous soft clear (driven by slave clear_o).
- evt_i  in  N_CORES*N_EVT  event pulses, [core][line].
- mask_i  in  N_EVT  per-line enable; static or quasi-static.
- ack_i  in  N_CORES*N_EVT  acknowledge pulses, [core][line]; level mode only.
- irq_o  out  N_CORES  interrupt request per core.
- irq_line_o  out  N_CORES*$clog2(N_EVT)  index of the lowest pending unmasked line per core.
- pending_o  out  N_CORES*N_EVT*CNT_WIDTH  counter values.
- overflow_o  out  N_CORES  sticky: an event was lost to saturation.

Behaviour:
- Reset (rst_ni low, async): all counters 0; irq_o, irq_line_o, overflow_o 0; every FSM in IDLE.
- clear_i: same reset values at the next edge. clear_i has priority over evt_i and ack_i in that cycle.
- Counter update per [c][l], each cycle, with inc = evt_i[c][l] and dec as defined per mode:
  - inc & !dec: +1, saturating. If inc arrives with the counter already at max, the counter holds and overflow_o[c] is set.
  - dec & !inc: -1. A dec at 0 is ignored; no underflow.
  - inc & dec: counter unchanged. Never flags overflow.
- Masked lines (mask_i[l] = 0) still count but do not contribute to irq_o or irq_line_o.
- pending_o is the registered counter value and is visible the cycle after the pulse.
- Level mode (PULSE_MODE = 0):
  - dec = ack_i[c][l].
  - irq_o[c] = registered OR over l of (counter != 0 & mask_i[l]).
  - Latency: evt_i at cycle t gives counter = 1 at t+1 and irq_o = 1 at t+2.
  - The ack that drops the last count gives irq_o = 0 two cycles later.
  - irq_line_o[c] is registered alongside irq_o (lowest pending unmasked index) and is 0 when none is pending.
- Pulse mode (PULSE_MODE = 1):
  - ack_i is ignored.
  - Per-core FSM states: IDLE, PULSE, GAP.
  - IDLE -> PULSE when any unmasked counter != 0. irq_o[c] = 1 for exactly the PULSE cycle; irq_line_o = lowest pending unmasked line, captured on entry to PULSE.
  - On the PULSE cycle, dec = 1 for the captured line only.
  - PULSE -> GAP unconditionally. GAP -> IDLE unconditionally, with irq_o = 0 in GAP.
  - Result: at most one pulse every 3 cycles. A burst of N events yields exactly N pulses.
  - An event arriving in any state is counted and never lost unless the counter saturates.
  - A line masked while its count is nonzero keeps its count and emits nothing until unmasked.
  - clear_i in PULSE or GAP forces IDLE with irq_o = 0 at the next edge.
- overflow_o[c] is cleared only by rst_ni or clear_i.
- Async reset mid-burst drops all pending counts.
- Lines are independent: simultaneous events on different cores or lines update independently in the same cycle.

Test Plan:
- Level mode:
  - Single event: evt_i[1][0] pulse at t -> pending_o[1][0] = 1 at t+1, irq_o = 4'b0010 at t+2; ack_i[1][0] at t+5 -> irq_o = 0 at t+7.
  - Simultaneous inc/dec: count = 3, evt_i and ack_i on the same line in one cycle -> count stays 3, irq_o stays 1, overflow_o = 0.
  - Saturation: CNT_WIDTH = 4, 16 back-to-back evt_i[0][1] -> counter = 15, overflow_o[0] = 1.
  - Ack at zero: ack_i with count = 0 -> count stays 0.
  - clear_i -> all counts 0, overflow_o = 0 at the next edge.
- Masking: mask_i = 2'b10, evt_i[2][0] -> count = 1, irq_o[2] = 0. Set mask_i = 2'b11 -> irq_o[2] = 1 two cycles later, irq_line_o[2] = 0.
- Pulse mode burst: 3 evt_i[3][0] pulses in consecutive cycles -> exactly 3 single-cycle irq_o[3] pulses 3 cycles apart, then count = 0.
- Pulse mode line priority: lines 0 and 1 both pending -> first pulse reports irq_line_o = 0, second reports 1.
- Pulse mode clear: clear_i during PULSE -> irq_o = 0 next cycle, counts 0, no further pulses.
- Async reset: assert rst_ni mid-burst between clock edges -> all outputs 0 immediately. After release, a new evt_i -> normal 2-cycle latency to irq_o.

Source files
------------

// File: rtl/hwpe_ctrl_evt_irq.sv
// Event-to-interrupt bridge: counts per-core event pulses from the HWPE control
// slave and turns them into level or spaced-pulse interrupt requests.
module hwpe_ctrl_evt_irq #(
  parameter int unsigned  N_CORES    = 4,
  parameter int unsigned  N_EVT      = 2,
  parameter int unsigned  CNT_WIDTH  = 4,
  parameter int unsigned  PULSE_MODE = 0,
  localparam int unsigned LINE_W     = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic [N_CORES*N_EVT-1:0]             evt_i,
  input  logic [N_EVT-1:0]                     mask_i,
  input  logic [N_CORES*N_EVT-1:0]             ack_i,
  output logic [N_CORES-1:0]                   irq_o,
  output logic [N_CORES*LINE_W-1:0]            irq_line_o,
  output logic [N_CORES*N_EVT*CNT_WIDTH-1:0]   pending_o,
  output logic [N_CORES-1:0]                   overflow_o
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // mask_i is quasi-static; one register stage keeps it off the compare paths
  // and makes unmask-to-irq take two cycles, like event-to-irq.
  logic [N_EVT-1:0] mask_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mask_q <= '0;
    else         mask_q <= mask_i;
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    logic [N_EVT-1:0]  vis;
    logic [N_EVT-1:0]  sat;
    logic [N_EVT-1:0]  scan;
    logic              any_vis;
    logic [LINE_W-1:0] low_idx;
    state_e            state_q;
    logic              irq_q;
    logic              ovf_q;
    logic [LINE_W-1:0] line_q;

    for (genvar l = 0; l < N_EVT; l++) begin : g_line
      logic                 inc;
      logic                 dec;
      logic [CNT_WIDTH-1:0] cnt_q;

      assign inc = evt_i[c*N_EVT + l];
      // In pulse mode the pulse itself consumes one count of the line it reports.
      assign dec = (PULSE_MODE != 0) ? ((state_q == PULSE) && (line_q == LINE_W'(l)))
                                     : ack_i[c*N_EVT + l];

      // NOTE: counters are plain flops holding live interrupt state, so each
      // one takes the async reset and updates with non-blocking assignments.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   cnt_q <= '0;
        else if (clear_i)                              cnt_q <= '0;
        else if (inc && !dec && (cnt_q != CNT_MAX))    cnt_q <= cnt_q + CNT_ONE;
        else if (!inc && dec && (cnt_q != '0))         cnt_q <= cnt_q - CNT_ONE;
      end

      assign sat[l] = inc & ~dec & (cnt_q == CNT_MAX);
      assign vis[l] = (cnt_q != '0) & mask_q[l];
      assign pending_o[(c*N_EVT + l)*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end

    // Lowest pending unmasked line; scanning high to low lets the lowest win.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
      any_vis = |vis;
      low_idx = '0;
      scan    = '0;
      for (int l = N_EVT - 1; l >= 0; l--) begin
        scan = vis >> l;
        if (scan[0]) low_idx = LINE_W'(l);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        irq_q   <= 1'b0;
        line_q  <= '0;
        ovf_q   <= 1'b0;
      end else if (clear_i) begin
        state_q <= IDLE;
        irq_q   <= 1'b0;
        line_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (|sat) ovf_q <= 1'b1;
        if (PULSE_MODE != 0) begin
          case (state_q)
            IDLE: begin
              if (any_vis) begin
                state_q <= PULSE;
                irq_q   <= 1'b1;
                line_q  <= low_idx;
              end
            end
            PULSE: begin
              state_q <= GAP;
              irq_q   <= 1'b0;
            end
            GAP:     state_q <= IDLE;
            default: begin
              state_q <= IDLE;
              irq_q   <= 1'b0;
            end
          endcase
        end else begin
          irq_q  <= any_vis;
          line_q <= low_idx;
        end
      end
    end

    assign irq_o[c]                        = irq_q;
    assign overflow_o[c]                   = ovf_q;
    assign irq_line_o[c*LINE_W +: LINE_W]  = line_q;
  end

endmodule

// File: tb/tb_hwpe_ctrl_evt_irq.sv
// Directed bench for hwpe_ctrl_evt_irq: one level-mode and one pulse-mode
// instance, table-driven level vectors plus hand-written multi-cycle sequences.
module tb_hwpe_ctrl_evt_irq;

  logic        clk_i;
  logic        rst_ni;

  logic [7:0]  lvl_evt, lvl_ack, pls_evt, pls_ack;
  logic        lvl_clr, pls_clr;
  logic [1:0]  lvl_mask, pls_mask;
  logic [3:0]  lvl_irq, lvl_line, lvl_ovf;
  logic [3:0]  pls_irq, pls_line, pls_ovf;
  logic [31:0] lvl_pend, pls_pend;

  int checks   = 0;
  int failures = 0;

  hwpe_ctrl_evt_irq #(
    .N_CORES(4), .N_EVT(2), .CNT_WIDTH(4), .PULSE_MODE(0)
  ) u_lvl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (lvl_clr),
    .evt_i      (lvl_evt),
    .mask_i     (lvl_mask),
    .ack_i      (lvl_ack),
    .irq_o      (lvl_irq),
    .irq_line_o (lvl_line),
    .pending_o  (lvl_pend),
    .overflow_o (lvl_ovf)
  );

  hwpe_ctrl_evt_irq #(
    .N_CORES(4), .N_EVT(2), .CNT_WIDTH(4), .PULSE_MODE(1)
  ) u_pls (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (pls_clr),
    .evt_i      (pls_evt),
    .mask_i     (pls_mask),
    .ack_i      (pls_ack),
    .irq_o      (pls_irq),
    .irq_line_o (pls_line),
    .pending_o  (pls_pend),
    .overflow_o (pls_ovf)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // pend hex digit k holds counter [k/2][k%2]; irq/line/ovf bit c is core c
  typedef struct packed {
    logic [7:0]  evt;
    logic [7:0]  ack;
    logic        clr;
    logic [1:0]  mask;
    logic [31:0] pend;
    logic [3:0]  irq;
    logic [3:0]  line;
    logic [3:0]  ovf;
  } vec_t;

  vec_t vecs [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [15:0] pat;
  logic [2:0]  other;
  logic [1:0]  line_rec;
  logic [3:0]  any_irq;

  initial begin
    //            evt    ack    clr  mask   pend          irq   line  ovf
    vecs[0]  = '{8'h04, 8'h00, 1'b0, 2'b11, 32'h0000_0100, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0100, 4'h2, 4'h0, 4'h0};
    vecs[2]  = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0100, 4'h2, 4'h0, 4'h0};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0100, 4'h2, 4'h0, 4'h0};
    vecs[4]  = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0100, 4'h2, 4'h0, 4'h0};
    vecs[5]  = '{8'h00, 8'h04, 1'b0, 2'b11, 32'h0000_0000, 4'h2, 4'h0, 4'h0};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{8'h01, 8'h00, 1'b0, 2'b11, 32'h0000_0001, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{8'h01, 8'h00, 1'b0, 2'b11, 32'h0000_0002, 4'h1, 4'h0, 4'h0};
    vecs[9]  = '{8'h01, 8'h00, 1'b0, 2'b11, 32'h0000_0003, 4'h1, 4'h0, 4'h0};
    vecs[10] = '{8'h01, 8'h01, 1'b0, 2'b11, 32'h0000_0003, 4'h1, 4'h0, 4'h0};
    vecs[11] = '{8'h00, 8'h01, 1'b0, 2'b11, 32'h0000_0002, 4'h1, 4'h0, 4'h0};
    vecs[12] = '{8'h00, 8'h01, 1'b0, 2'b11, 32'h0000_0001, 4'h1, 4'h0, 4'h0};
    vecs[13] = '{8'h00, 8'h01, 1'b0, 2'b11, 32'h0000_0000, 4'h1, 4'h0, 4'h0};
    vecs[14] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    vecs[15] = '{8'h00, 8'h01, 1'b0, 2'b11, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    vecs[16] = '{8'h80, 8'h00, 1'b0, 2'b11, 32'h1000_0000, 4'h0, 4'h0, 4'h0};
    vecs[17] = '{8'h40, 8'h00, 1'b0, 2'b11, 32'h1100_0000, 4'h8, 4'h8, 4'h0};
    vecs[18] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h1100_0000, 4'h8, 4'h0, 4'h0};
    vecs[19] = '{8'h00, 8'h40, 1'b0, 2'b11, 32'h1000_0000, 4'h8, 4'h0, 4'h0};
    vecs[20] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h1000_0000, 4'h8, 4'h8, 4'h0};
    vecs[21] = '{8'h80, 8'h00, 1'b1, 2'b11, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    vecs[22] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    vecs[23] = '{8'h10, 8'h00, 1'b0, 2'b10, 32'h0001_0000, 4'h0, 4'h0, 4'h0};
    vecs[24] = '{8'h00, 8'h00, 1'b0, 2'b10, 32'h0001_0000, 4'h0, 4'h0, 4'h0};
    vecs[25] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0001_0000, 4'h0, 4'h0, 4'h0};
    vecs[26] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0001_0000, 4'h4, 4'h0, 4'h0};
    vecs[27] = '{8'h00, 8'h10, 1'b0, 2'b11, 32'h0000_0000, 4'h4, 4'h0, 4'h0};
    vecs[28] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    vecs[29] = '{8'hFF, 8'h00, 1'b0, 2'b11, 32'h1111_1111, 4'h0, 4'h0, 4'h0};
    vecs[30] = '{8'h00, 8'h00, 1'b0, 2'b11, 32'h1111_1111, 4'hF, 4'h0, 4'h0};
    vecs[31] = '{8'h00, 8'h00, 1'b1, 2'b11, 32'h0000_0000, 4'h0, 4'h0, 4'h0};

    rst_ni   = 1'b0;
    lvl_evt  = '0; lvl_ack = '0; lvl_clr = 1'b0; lvl_mask = 2'b11;
    pls_evt  = '0; pls_ack = '0; pls_clr = 1'b0; pls_mask = 2'b11;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();

    check("rst.lvl_pend", lvl_pend, 32'h0);
    check("rst.lvl_irq",  {28'h0, lvl_irq},  32'h0);
    check("rst.lvl_line", {28'h0, lvl_line}, 32'h0);
    check("rst.lvl_ovf",  {28'h0, lvl_ovf},  32'h0);
    check("rst.pls_pend", pls_pend, 32'h0);
    check("rst.pls_irq",  {28'h0, pls_irq},  32'h0);
    check("rst.pls_line", {28'h0, pls_line}, 32'h0);
    check("rst.pls_ovf",  {28'h0, pls_ovf},  32'h0);

    // Level mode vectors: each row is driven for one cycle, outputs checked after the edge
    for (int i = 0; i < 32; i++) begin
      lvl_evt  = vecs[i].evt;
      lvl_ack  = vecs[i].ack;
      lvl_clr  = vecs[i].clr;
      lvl_mask = vecs[i].mask;
      tick();
      check($sformatf("vec%0d.pend", i), lvl_pend, vecs[i].pend);
      check($sformatf("vec%0d.irq", i),  {28'h0, lvl_irq},  {28'h0, vecs[i].irq});
      check($sformatf("vec%0d.line", i), {28'h0, lvl_line}, {28'h0, vecs[i].line});
      check($sformatf("vec%0d.ovf", i),  {28'h0, lvl_ovf},  {28'h0, vecs[i].ovf});
    end
    lvl_evt = '0; lvl_ack = '0; lvl_clr = 1'b0; lvl_mask = 2'b11;

    // Saturation on [0][1]: 15 events fill it, the 16th is lost and flags overflow
    lvl_evt = 8'h02;
    repeat (15) tick();
    check("sat15.pend", lvl_pend, 32'h0000_00F0);
    check("sat15.ovf",  {28'h0, lvl_ovf}, 32'h0);
    tick();
    check("sat16.pend", lvl_pend, 32'h0000_00F0);
    check("sat16.ovf",  {28'h0, lvl_ovf}, 32'h1);
    lvl_evt = '0;
    tick();
    check("sat.irq",  {28'h0, lvl_irq},  32'h1);
    check("sat.line", {28'h0, lvl_line}, 32'h1);
    lvl_clr = 1'b1;
    tick();
    lvl_clr = 1'b0;
    check("satclr.pend", lvl_pend, 32'h0);
    check("satclr.ovf",  {28'h0, lvl_ovf}, 32'h0);

    // inc and dec together at the saturation point never flag overflow
    lvl_evt = 8'h04;
    repeat (15) tick();
    lvl_ack = 8'h04;
    tick();
    lvl_evt = '0; lvl_ack = '0;
    check("incdec_max.pend", lvl_pend, 32'h0000_0F00);
    check("incdec_max.ovf",  {28'h0, lvl_ovf}, 32'h0);
    lvl_clr = 1'b1;
    tick();
    lvl_clr = 1'b0;

    // Pulse mode burst on [3][0] with ack held high (must be ignored)
    pat = '0; other = '0;
    pls_ack = 8'hFF;
    pls_evt = 8'h40;
    for (int i = 1; i <= 14; i++) begin
      tick();
      pat   = {pat[14:0], pls_irq[3]};
      other = other | pls_irq[2:0];
      if (i == 3) pls_evt = '0;
    end
    pls_ack = '0;
    check("burst.pattern", {16'h0, pat}, 32'h0000_1240);
    check("burst.other_cores", {29'h0, other}, 32'h0);
    check("burst.pend_end", pls_pend, 32'h0);

    // Pulse mode line priority: both lines of core 0 pending at once
    pat = '0; line_rec = '0;
    pls_evt = 8'h03;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) pls_evt = '0;
      pat = {pat[14:0], pls_irq[0]};
      if (pls_irq[0]) line_rec = {line_rec[0], pls_line[0]};
    end
    check("prio.pattern", {16'h0, pat}, 32'h0000_0120);
    check("prio.lines",   {30'h0, line_rec}, 32'h1);
    check("prio.pend_end", pls_pend, 32'h0);

    // Pulse mode clear while in PULSE
    pls_evt = 8'h10;
    tick();
    tick();
    pls_evt = '0;
    check("pclr.in_pulse", {28'h0, pls_irq}, 32'h4);
    pls_clr = 1'b1;
    tick();
    pls_clr = 1'b0;
    check("pclr.irq", {28'h0, pls_irq}, 32'h0);
    check("pclr.pend", pls_pend, 32'h0);
    any_irq = '0;
    repeat (8) begin
      tick();
      any_irq = any_irq | pls_irq;
    end
    check("pclr.no_more_pulses", {28'h0, any_irq}, 32'h0);

    // Async reset in the middle of a burst on both instances
    lvl_evt = 8'h04; pls_evt = 8'h04;
    repeat (3) tick();
    lvl_evt = '0; pls_evt = '0;
    tick();
    check("pre_arst.lvl_pend", lvl_pend, 32'h0000_0300);
    #3 rst_ni = 1'b0;
    #1;
    check("arst.lvl_pend", lvl_pend, 32'h0);
    check("arst.lvl_outs", {20'h0, lvl_irq, lvl_line, lvl_ovf}, 32'h0);
    check("arst.pls_pend", pls_pend, 32'h0);
    check("arst.pls_outs", {20'h0, pls_irq, pls_line, pls_ovf}, 32'h0);
    #2 rst_ni = 1'b1;
    tick();
    lvl_evt = 8'h04;
    tick();
    lvl_evt = '0;
    check("post_arst.pend", lvl_pend, 32'h0000_0100);
    check("post_arst.irq_t1", {28'h0, lvl_irq}, 32'h0);
    tick();
    check("post_arst.irq_t2", {28'h0, lvl_irq}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
